// File: rtl/tmr_irq_pkg.sv
// Shared types and helpers for the timer interrupt arbiter.
// Source indices follow the timer unit's interrupt ordering.
package tmr_irq_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ASSERT,
      CLEAR
   } state_t;

   localparam int NUM_SRC_DFLT = 6;

   localparam int SRC_CMIA0 = 0;
   localparam int SRC_CMIB0 = 1;
   localparam int SRC_OVI0  = 2;
   localparam int SRC_CMIA1 = 3;
   localparam int SRC_CMIB1 = 4;
   localparam int SRC_OVI1  = 5;

   function automatic int mod_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/tmr_irq_picker.sv
// Combinational winner search: lowest index first, or a
// wrapping search starting at the round-robin pointer.
module tmr_irq_picker
   import tmr_irq_pkg::*;
#(
   parameter int NUM_SRC = NUM_SRC_DFLT,
   parameter int VEC_W   = 3
) (
   input  logic [NUM_SRC-1:0] req,
   input  logic [VEC_W-1:0]   ptr,
   input  logic               rr_en,
   output logic               valid,
   output logic [VEC_W-1:0]   winner
);

   int base;
   int k;

   // Scan from the far end so the nearest hit overwrites last.
   always_comb begin
      valid  = 1'b0;
      winner = '0;
      k      = 0;
      base   = rr_en ? int'(ptr) : 0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         k = base + i;
         if (k >= NUM_SRC) begin
            k = k - NUM_SRC;
         end
         if (req[k]) begin
            valid  = 1'b1;
            winner = VEC_W'(k);
         end
      end
   end

endmodule

// File: rtl/tmr_irq_arbiter.sv
// Shares one CPU interrupt line among the timer sources with
// edge capture, overrun tracking and an ack timeout.
module tmr_irq_arbiter
   import tmr_irq_pkg::*;
#(
   parameter int NUM_SRC     = NUM_SRC_DFLT,
   parameter int VEC_W       = 3,
   parameter int ACK_TIMEOUT = 255,
   parameter int TO_W        = 8
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [NUM_SRC-1:0] i_irq_src,
   input  logic [NUM_SRC-1:0] i_irq_mask,
   input  logic               i_rr_en,
   input  logic               i_irq_ack,
   input  logic [NUM_SRC-1:0] i_ovr_clr,
   output logic               o_irq,
   output logic [VEC_W-1:0]   o_irq_vec,
   output logic [NUM_SRC-1:0] o_pending,
   output logic [NUM_SRC-1:0] o_overrun,
   output logic               o_timeout
);

   localparam bit            TO_EN   = (ACK_TIMEOUT != 0);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

   state_t             state;
   state_t             state_n;
   logic [NUM_SRC-1:0] prev;
   logic [NUM_SRC-1:0] pending;
   logic [NUM_SRC-1:0] pending_n;
   logic [NUM_SRC-1:0] overrun;
   logic [NUM_SRC-1:0] overrun_n;
   logic [NUM_SRC-1:0] evt;
   logic [NUM_SRC-1:0] ack_clr;
   logic [VEC_W-1:0]   rr_ptr;
   logic [VEC_W-1:0]   rr_n;
   logic [VEC_W-1:0]   rr_inc;
   logic [TO_W-1:0]    cnt;
   logic [TO_W-1:0]    cnt_n;
   logic               irq_n;
   logic [VEC_W-1:0]   vec_n;
   logic               to_n;
   logic               pick_valid;
   logic [VEC_W-1:0]   pick_win;

   tmr_irq_picker #(
      .NUM_SRC (NUM_SRC),
      .VEC_W   (VEC_W)
   ) u_picker (
      .req    (pending & ~i_irq_mask),
      .ptr    (rr_ptr),
      .rr_en  (i_rr_en),
      .valid  (pick_valid),
      .winner (pick_win)
   );

   assign rr_inc    = VEC_W'(mod_inc(int'(o_irq_vec), NUM_SRC));
   assign o_pending = pending;
   assign o_overrun = overrun;

   always_comb begin
      state_n = state;
      irq_n   = o_irq;
      vec_n   = o_irq_vec;
      to_n    = 1'b0;
      rr_n    = rr_ptr;
      cnt_n   = cnt;
      ack_clr = '0;
      unique case (state)
         IDLE: begin
            cnt_n = '0;
            if (pick_valid) begin
               state_n = ASSERT;
               irq_n   = 1'b1;
               vec_n   = pick_win;
            end
         end
         ASSERT: begin
            cnt_n = cnt + TO_W'(1);
            if (i_irq_ack) begin
               for (int i = 0; i < NUM_SRC; i++) begin
                  ack_clr[i] = (VEC_W'(i) == o_irq_vec);
               end
               irq_n   = 1'b0;
               rr_n    = rr_inc;
               state_n = CLEAR;
            end else if (TO_EN && cnt == TO_LAST) begin
               // Give up but leave the request pending for a retry.
               to_n    = 1'b1;
               irq_n   = 1'b0;
               rr_n    = rr_inc;
               state_n = CLEAR;
            end
         end
         CLEAR: begin
            cnt_n   = '0;
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // A new edge beats both the ack clear and the overrun clear.
   always_comb begin
      evt       = i_irq_src & ~prev;
      pending_n = (pending & ~ack_clr) | evt;
      overrun_n = (overrun & ~i_ovr_clr)
                | (evt & pending & ~ack_clr);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state     <= IDLE;
         prev      <= '1;
         pending   <= '0;
         overrun   <= '0;
         rr_ptr    <= '0;
         cnt       <= '0;
         o_irq     <= 1'b0;
         o_irq_vec <= '0;
         o_timeout <= 1'b0;
      end else begin
         state     <= state_n;
         prev      <= i_irq_src;
         pending   <= pending_n;
         overrun   <= overrun_n;
         rr_ptr    <= rr_n;
         cnt       <= cnt_n;
         o_irq     <= irq_n;
         o_irq_vec <= vec_n;
         o_timeout <= to_n;
      end
   end

endmodule

// File: tb/tb_tmr_irq_arbiter.sv
// Directed bench for tmr_irq_arbiter: vector table for the
// arbitration orders plus hand sequences for timing corners.
module tb_tmr_irq_arbiter;

   logic       clk;
   logic       rst;
   logic [5:0] src;
   logic [5:0] mask;
   logic       rr;
   logic       ack;
   logic [5:0] clr;
   logic       irq;
   logic [2:0] vec;
   logic [5:0] pend;
   logic [5:0] ovr;
   logic       tout;

   int n_chk;
   int n_fail;

   typedef struct {
      logic [5:0] src;
      logic [5:0] mask;
      logic       rr;
      logic       ack;
      logic [5:0] clr;
      logic       e_irq;
      logic [2:0] e_vec;
      logic [5:0] e_pend;
      logic [5:0] e_ovr;
      logic       e_to;
   } row_t;

   row_t tbl[$];
   int   t2_start;

   tmr_irq_arbiter #(
      .NUM_SRC     (6),
      .VEC_W       (3),
      .ACK_TIMEOUT (4),
      .TO_W        (8)
   ) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_irq_src  (src),
      .i_irq_mask (mask),
      .i_rr_en    (rr),
      .i_irq_ack  (ack),
      .i_ovr_clr  (clr),
      .o_irq      (irq),
      .o_irq_vec  (vec),
      .o_pending  (pend),
      .o_overrun  (ovr),
      .o_timeout  (tout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic add(input logic [5:0] s, input logic a,
                      input logic r, input logic e_irq,
                      input logic [2:0] e_vec,
                      input logic [5:0] e_pend);
      row_t w;
      w.src    = s;
      w.mask   = 6'h00;
      w.rr     = r;
      w.ack    = a;
      w.clr    = 6'h00;
      w.e_irq  = e_irq;
      w.e_vec  = e_vec;
      w.e_pend = e_pend;
      w.e_ovr  = 6'h00;
      w.e_to   = 1'b0;
      tbl.push_back(w);
   endtask

   task automatic step(input logic [5:0] s, input logic [5:0] m,
                       input logic r, input logic a,
                       input logic [5:0] c);
      @(negedge clk);
      src  = s;
      mask = m;
      rr   = r;
      ack  = a;
      clr  = c;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_o(input string nm, input logic e_irq,
                           input logic [2:0] e_vec,
                           input logic [5:0] e_pend,
                           input logic [5:0] e_ovr,
                           input logic e_to);
      n_chk++;
      if ({irq, vec, pend, ovr, tout} !==
          {e_irq, e_vec, e_pend, e_ovr, e_to}) begin
         n_fail++;
         $display("FAIL %s: got irq=%0b vec=%0d pend=%h ovr=%h to=%0b, want irq=%0b vec=%0d pend=%h ovr=%h to=%0b",
                  nm, irq, vec, pend, ovr, tout,
                  e_irq, e_vec, e_pend, e_ovr, e_to);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst  = 1'b1;
      src  = '0;
      mask = '0;
      rr   = 1'b0;
      ack  = 1'b0;
      clr  = '0;
      @(negedge clk);
      rst  = 1'b0;
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      rst    = 1'b1;
      src    = '0;
      mask   = '0;
      rr     = 1'b0;
      ack    = 1'b0;
      clr    = '0;

      // Test 1: fixed priority, src 2 and 4 together.
      add(6'h00, 0, 0, 0, 0, 6'h00);
      add(6'h14, 0, 0, 0, 0, 6'h14);
      add(6'h14, 0, 0, 1, 2, 6'h14);
      add(6'h14, 1, 0, 0, 2, 6'h10);
      add(6'h14, 0, 0, 0, 2, 6'h10);
      add(6'h14, 0, 0, 1, 4, 6'h10);
      add(6'h14, 1, 0, 0, 4, 6'h00);
      add(6'h00, 0, 0, 0, 4, 6'h00);
      add(6'h00, 0, 0, 0, 4, 6'h00);
      // Test 2: round robin over 0, 1, 5 then 0, 5.
      t2_start = tbl.size();
      add(6'h00, 0, 1, 0, 0, 6'h00);
      add(6'h23, 0, 1, 0, 0, 6'h23);
      add(6'h23, 0, 1, 1, 0, 6'h23);
      add(6'h23, 1, 1, 0, 0, 6'h22);
      add(6'h23, 0, 1, 0, 0, 6'h22);
      add(6'h23, 0, 1, 1, 1, 6'h22);
      add(6'h23, 1, 1, 0, 1, 6'h20);
      add(6'h23, 0, 1, 0, 1, 6'h20);
      add(6'h23, 0, 1, 1, 5, 6'h20);
      add(6'h00, 1, 1, 0, 5, 6'h00);
      add(6'h00, 0, 1, 0, 5, 6'h00);
      add(6'h21, 0, 1, 0, 5, 6'h21);
      add(6'h21, 0, 1, 1, 0, 6'h21);
      add(6'h21, 1, 1, 0, 0, 6'h20);
      add(6'h21, 0, 1, 0, 0, 6'h20);
      add(6'h21, 0, 1, 1, 5, 6'h20);
      add(6'h21, 1, 1, 0, 5, 6'h00);
      add(6'h00, 0, 1, 0, 5, 6'h00);

      #1;
      expect_o("reset_state", 0, 0, 6'h00, 6'h00, 0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         if (i == t2_start) begin
            do_reset();
         end
         step(tbl[i].src, tbl[i].mask, tbl[i].rr,
              tbl[i].ack, tbl[i].clr);
         expect_o($sformatf("row%0d", i), tbl[i].e_irq,
                  tbl[i].e_vec, tbl[i].e_pend,
                  tbl[i].e_ovr, tbl[i].e_to);
      end

      // Test 3: ack timeout after four ASSERT cycles.
      do_reset();
      step(6'h00, 0, 0, 0, 0);
      step(6'h08, 0, 0, 0, 0);
      expect_o("to_pend", 0, 0, 6'h08, 6'h00, 0);
      for (int i = 0; i < 4; i++) begin
         step(6'h08, 0, 0, 0, 0);
         expect_o($sformatf("to_high%0d", i),
                  1, 3, 6'h08, 6'h00, 0);
      end
      step(6'h08, 0, 0, 0, 0);
      expect_o("to_pulse", 0, 3, 6'h08, 6'h00, 1);
      step(6'h08, 0, 0, 0, 0);
      expect_o("to_low2", 0, 3, 6'h08, 6'h00, 0);
      step(6'h08, 0, 0, 0, 0);
      expect_o("to_retry", 1, 3, 6'h08, 6'h00, 0);
      step(6'h08, 0, 0, 1, 0);
      expect_o("to_ack", 0, 3, 6'h00, 6'h00, 0);

      // Test 4: overrun, clear, and set-wins cases.
      do_reset();
      step(6'h00, 0, 0, 0, 0);
      step(6'h02, 0, 0, 0, 0);
      expect_o("ov_pend", 0, 0, 6'h02, 6'h00, 0);
      step(6'h00, 0, 0, 0, 0);
      expect_o("ov_irq", 1, 1, 6'h02, 6'h00, 0);
      step(6'h02, 0, 0, 0, 0);
      expect_o("ov_set", 1, 1, 6'h02, 6'h02, 0);
      step(6'h00, 0, 0, 1, 0);
      expect_o("ov_ack", 0, 1, 6'h00, 6'h02, 0);
      step(6'h00, 0, 0, 0, 6'h02);
      expect_o("ov_clr", 0, 1, 6'h00, 6'h00, 0);
      step(6'h02, 0, 0, 0, 0);
      step(6'h00, 0, 0, 0, 0);
      expect_o("cw_irq", 1, 1, 6'h02, 6'h00, 0);
      step(6'h02, 0, 0, 1, 0);
      expect_o("cw_ack_edge", 0, 1, 6'h02, 6'h00, 0);
      step(6'h00, 0, 0, 0, 0);
      step(6'h00, 0, 0, 0, 0);
      expect_o("cw_reirq", 1, 1, 6'h02, 6'h00, 0);
      step(6'h00, 0, 0, 1, 0);
      step(6'h02, 0, 0, 0, 0);
      step(6'h00, 0, 0, 0, 0);
      step(6'h02, 0, 0, 0, 6'h02);
      expect_o("sc_setwins", 1, 1, 6'h02, 6'h02, 0);
      step(6'h00, 0, 0, 1, 0);
      step(6'h00, 0, 0, 0, 6'h02);
      expect_o("sc_clr", 0, 1, 6'h00, 6'h00, 0);

      // Test 5: mask blocks arbitration but not a live service.
      do_reset();
      step(6'h00, 6'h01, 0, 0, 0);
      step(6'h01, 6'h01, 0, 0, 0);
      expect_o("mk_pend", 0, 0, 6'h01, 6'h00, 0);
      step(6'h01, 6'h01, 0, 0, 0);
      step(6'h01, 6'h01, 0, 0, 0);
      expect_o("mk_block", 0, 0, 6'h01, 6'h00, 0);
      step(6'h01, 6'h00, 0, 0, 0);
      expect_o("mk_unmask", 1, 0, 6'h01, 6'h00, 0);
      step(6'h01, 6'h01, 0, 0, 0);
      step(6'h01, 6'h01, 0, 0, 0);
      expect_o("mk_hold", 1, 0, 6'h01, 6'h00, 0);
      step(6'h01, 6'h01, 0, 1, 0);
      expect_o("mk_ack", 0, 0, 6'h00, 6'h00, 0);

      // Test 6: reset mid-ASSERT with the source held high.
      do_reset();
      step(6'h00, 0, 0, 0, 0);
      step(6'h20, 0, 0, 0, 0);
      step(6'h20, 0, 0, 0, 0);
      expect_o("rs_irq", 1, 5, 6'h20, 6'h00, 0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      expect_o("rs_async", 0, 0, 6'h00, 6'h00, 0);
      @(negedge clk);
      rst = 1'b0;
      step(6'h20, 0, 0, 0, 0);
      step(6'h20, 0, 0, 0, 0);
      expect_o("rs_noevt", 0, 0, 6'h00, 6'h00, 0);
      step(6'h00, 0, 0, 0, 0);
      step(6'h20, 0, 0, 0, 0);
      expect_o("rs_repend", 0, 0, 6'h20, 6'h00, 0);
      step(6'h20, 0, 0, 0, 0);
      expect_o("rs_reirq", 1, 5, 6'h20, 6'h00, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
